cellrv32_bus_gateway: RTL and testbench



---
 rtl/cellrv32_package.sv | 29 ++
 rtl/cellrv32_bus_gateway_if.sv | 16 +
 rtl/cellrv32_bus_gateway_decode.sv | 38 +++
 rtl/cellrv32_bus_gateway.sv | 175 +++++++++++++++++
 tb/tb_cellrv32_bus_gateway.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cellrv32_package.sv
// Shared types for the CELLRV32 bus gateway: target selection, FSM states,
// timeout counter width and the power-of-two region hit test.
package cellrv32_package;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_IMEM,
    SEL_DMEM,
    SEL_IO,
    SEL_EXT
  } gw_sel_t;

  typedef enum logic [1:0] {
    GW_IDLE,
    GW_BUSY,
    GW_ERR
  } gw_state_t;

  localparam int unsigned GW_TMO_W = 16;

  // Region sizes are powers of two and bases are size-aligned, so a mask compare suffices.
  function automatic logic gw_hit(input logic [31:0] addr, input logic [31:0] base,
                                  input int unsigned size);
    logic [31:0] mask;
    mask = ~(size - 32'd1);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/cellrv32_bus_gateway_if.sv
// Initiator-side peripheral bus bundle: the CPU/DMA switch is the master,
// the gateway is the slave.
interface cellrv32_bus_gateway_if;
  logic        priv;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  ben;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (output priv, addr, wdata, ben, we, re, input rdata, ack, err);
  modport slave  (input priv, addr, wdata, ben, we, re, output rdata, ack, err);
endinterface

// File: rtl/cellrv32_bus_gateway_decode.sv
// Combinational address decoder: picks the target region (IMEM > DMEM > IO > EXT)
// and flags user-mode accesses to the IO region.
module cellrv32_bus_gateway_decode
  import cellrv32_package::*;
#(
  parameter bit          IMEM_EN   = 1'b1,
  parameter logic [31:0] IMEM_BASE = 32'h0000_0000,
  parameter int unsigned IMEM_SIZE = 16384,
  parameter bit          DMEM_EN   = 1'b1,
  parameter logic [31:0] DMEM_BASE = 32'h8000_0000,
  parameter int unsigned DMEM_SIZE = 8192,
  parameter logic [31:0] IO_BASE   = 32'hFFFF_FE00,
  parameter int unsigned IO_SIZE   = 512,
  parameter bit          EXT_EN    = 1'b0
) (
  input  logic [31:0] addr_i,
  input  logic        priv_i,
  output gw_sel_t     sel_o,
  output logic        priv_err_o
);

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    sel_o      = SEL_NONE;
    priv_err_o = 1'b0;
    if (IMEM_EN && gw_hit(addr_i, IMEM_BASE, IMEM_SIZE)) begin
      sel_o = SEL_IMEM;
    end else if (DMEM_EN && gw_hit(addr_i, DMEM_BASE, DMEM_SIZE)) begin
      sel_o = SEL_DMEM;
    end else if (gw_hit(addr_i, IO_BASE, IO_SIZE)) begin
      sel_o      = SEL_IO;
      priv_err_o = ~priv_i;
    end else if (EXT_EN) begin
      sel_o = SEL_EXT;
    end
  end

endmodule

// File: rtl/cellrv32_bus_gateway.sv
// Single-initiator to multi-target bus gateway with locally generated error responses.
// Optional response timeout: define CELLRV32_BUS_GATEWAY_TIMEOUT_EN.
module cellrv32_bus_gateway
  import cellrv32_package::*;
#(
  parameter bit          IMEM_EN    = 1'b1,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_0000,
  parameter int unsigned IMEM_SIZE  = 16384,
  parameter bit          DMEM_EN    = 1'b1,
  parameter logic [31:0] DMEM_BASE  = 32'h8000_0000,
  parameter int unsigned DMEM_SIZE  = 8192,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FE00,
  parameter int unsigned IO_SIZE    = 512,
  parameter bit          EXT_EN     = 1'b0,
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  cellrv32_bus_gateway_if.slave         p_bus,
  output logic [31:0]                   t_addr_o,
  output logic [31:0]                   t_wdata_o,
  output logic [3:0]                    t_ben_o,
  output logic                          imem_we_o,
  output logic                          imem_re_o,
  input  logic [31:0]                   imem_rdata_i,
  input  logic                          imem_ack_i,
  input  logic                          imem_err_i,
  output logic                          dmem_we_o,
  output logic                          dmem_re_o,
  input  logic [31:0]                   dmem_rdata_i,
  input  logic                          dmem_ack_i,
  input  logic                          dmem_err_i,
  output logic                          io_we_o,
  output logic                          io_re_o,
  input  logic [31:0]                   io_rdata_i,
  input  logic                          io_ack_i,
  input  logic                          io_err_i,
  output logic                          ext_we_o,
  output logic                          ext_re_o,
  input  logic [31:0]                   ext_rdata_i,
  input  logic                          ext_ack_i,
  input  logic                          ext_err_i
);

  gw_state_t   state_q, state_d;
  gw_sel_t     sel_q, sel_d;
  gw_sel_t     dec_sel;
  logic        dec_priv_err;
  logic        req, req_ok;
  logic [31:0] sel_rdata;
  logic        sel_ack, sel_err;
`ifdef CELLRV32_BUS_GATEWAY_TIMEOUT_EN
  logic [GW_TMO_W-1:0] tmo_q, tmo_d;
`endif

  assign t_addr_o  = p_bus.addr;
  assign t_wdata_o = p_bus.wdata;
  assign t_ben_o   = p_bus.ben;

  cellrv32_bus_gateway_decode #(
    .IMEM_EN  (IMEM_EN),
    .IMEM_BASE(IMEM_BASE),
    .IMEM_SIZE(IMEM_SIZE),
    .DMEM_EN  (DMEM_EN),
    .DMEM_BASE(DMEM_BASE),
    .DMEM_SIZE(DMEM_SIZE),
    .IO_BASE  (IO_BASE),
    .IO_SIZE  (IO_SIZE),
    .EXT_EN   (EXT_EN)
  ) u_decode (
    .addr_i    (p_bus.addr),
    .priv_i    (p_bus.priv),
    .sel_o     (dec_sel),
    .priv_err_o(dec_priv_err)
  );

  assign req    = p_bus.re | p_bus.we;
  assign req_ok = req && !(p_bus.re && p_bus.we) && (dec_sel != SEL_NONE) && !dec_priv_err;

  // Only the latched target's response is visible; all others are ignored.
  always_comb begin
    sel_rdata = '0;
    sel_ack   = 1'b0;
    sel_err   = 1'b0;
    case (sel_q)
      SEL_IMEM: begin sel_rdata = imem_rdata_i; sel_ack = imem_ack_i; sel_err = imem_err_i; end
      SEL_DMEM: begin sel_rdata = dmem_rdata_i; sel_ack = dmem_ack_i; sel_err = dmem_err_i; end
      SEL_IO:   begin sel_rdata = io_rdata_i;   sel_ack = io_ack_i;   sel_err = io_err_i;   end
      SEL_EXT:  begin sel_rdata = ext_rdata_i;  sel_ack = ext_ack_i;  sel_err = ext_err_i;  end
      default:  ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    imem_we_o   = 1'b0;
    imem_re_o   = 1'b0;
    dmem_we_o   = 1'b0;
    dmem_re_o   = 1'b0;
    io_we_o     = 1'b0;
    io_re_o     = 1'b0;
    ext_we_o    = 1'b0;
    ext_re_o    = 1'b0;
    p_bus.rdata = '0;
    p_bus.ack   = 1'b0;
    p_bus.err   = 1'b0;
`ifdef CELLRV32_BUS_GATEWAY_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      GW_IDLE: begin
        if (req && !rst_i) begin
          if (req_ok) begin
            state_d = GW_BUSY;
            sel_d   = dec_sel;
`ifdef CELLRV32_BUS_GATEWAY_TIMEOUT_EN
            tmo_d   = GW_TMO_W'(TMO_CYCLES - 1);
`endif
            case (dec_sel)
              SEL_IMEM: begin imem_re_o = p_bus.re; imem_we_o = p_bus.we; end
              SEL_DMEM: begin dmem_re_o = p_bus.re; dmem_we_o = p_bus.we; end
              SEL_IO:   begin io_re_o   = p_bus.re; io_we_o   = p_bus.we; end
              SEL_EXT:  begin ext_re_o  = p_bus.re; ext_we_o  = p_bus.we; end
              default:  ;
            endcase
          end else begin
            state_d = GW_ERR;
          end
        end
      end
      GW_BUSY: begin
        p_bus.rdata = sel_rdata;
        p_bus.ack   = sel_ack & ~sel_err;
        p_bus.err   = sel_err;
        if (sel_ack || sel_err) begin
          state_d = GW_IDLE;
          sel_d   = SEL_NONE;
        end
`ifdef CELLRV32_BUS_GATEWAY_TIMEOUT_EN
        else if (tmo_q == '0) begin
          p_bus.err = 1'b1;
          state_d   = GW_IDLE;
          sel_d     = SEL_NONE;
        end else begin
          tmo_d = tmo_q - GW_TMO_W'(1);
        end
`endif
      end
      GW_ERR: begin
        p_bus.err = 1'b1;
        state_d   = GW_IDLE;
      end
      default: state_d = GW_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= GW_IDLE;
      sel_q   <= SEL_NONE;
`ifdef CELLRV32_BUS_GATEWAY_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
`ifdef CELLRV32_BUS_GATEWAY_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_cellrv32_bus_gateway.sv
// Directed bench for cellrv32_bus_gateway: a decode/response vector table plus
// hand-written multi-cycle sequences (back-pressure, reset, external region, timeout).
module tb_cellrv32_bus_gateway;
  import cellrv32_package::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cellrv32_bus_gateway_if bus ();
  cellrv32_bus_gateway_if bus_x ();

  logic [31:0] imem_rdata, dmem_rdata, io_rdata, ext_rdata;
  logic        imem_ack, dmem_ack, io_ack, ext_ack;
  logic        imem_err, dmem_err, io_err, ext_err;

  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_ben;
  logic        imem_we, imem_re, dmem_we, dmem_re, io_we, io_re, ext_we, ext_re;
  logic [31:0] x_t_addr, x_t_wdata;
  logic [3:0]  x_t_ben;
  logic        x_imem_we, x_imem_re, x_dmem_we, x_dmem_re, x_io_we, x_io_re, x_ext_we, x_ext_re;
  logic [7:0]  strb;

  assign strb = {imem_we, imem_re, dmem_we, dmem_re, io_we, io_re, ext_we, ext_re};

  cellrv32_bus_gateway #(.EXT_EN(1'b0), .TMO_CYCLES(4)) u_dut (
    .clk_i(clk), .rst_i(rst), .p_bus(bus),
    .t_addr_o(t_addr), .t_wdata_o(t_wdata), .t_ben_o(t_ben),
    .imem_we_o(imem_we), .imem_re_o(imem_re), .imem_rdata_i(imem_rdata), .imem_ack_i(imem_ack), .imem_err_i(imem_err),
    .dmem_we_o(dmem_we), .dmem_re_o(dmem_re), .dmem_rdata_i(dmem_rdata), .dmem_ack_i(dmem_ack), .dmem_err_i(dmem_err),
    .io_we_o(io_we), .io_re_o(io_re), .io_rdata_i(io_rdata), .io_ack_i(io_ack), .io_err_i(io_err),
    .ext_we_o(ext_we), .ext_re_o(ext_re), .ext_rdata_i(ext_rdata), .ext_ack_i(ext_ack), .ext_err_i(ext_err)
  );

  cellrv32_bus_gateway #(.EXT_EN(1'b1), .TMO_CYCLES(4)) u_dut_ext (
    .clk_i(clk), .rst_i(rst), .p_bus(bus_x),
    .t_addr_o(x_t_addr), .t_wdata_o(x_t_wdata), .t_ben_o(x_t_ben),
    .imem_we_o(x_imem_we), .imem_re_o(x_imem_re), .imem_rdata_i(imem_rdata), .imem_ack_i(imem_ack), .imem_err_i(imem_err),
    .dmem_we_o(x_dmem_we), .dmem_re_o(x_dmem_re), .dmem_rdata_i(dmem_rdata), .dmem_ack_i(dmem_ack), .dmem_err_i(dmem_err),
    .io_we_o(x_io_we), .io_re_o(x_io_re), .io_rdata_i(io_rdata), .io_ack_i(io_ack), .io_err_i(io_err),
    .ext_we_o(x_ext_we), .ext_re_o(x_ext_re), .ext_rdata_i(ext_rdata), .ext_ack_i(ext_ack), .ext_err_i(ext_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.re = 1'b0; bus.we = 1'b0; bus.priv = 1'b0;
    bus.addr = '0; bus.wdata = '0; bus.ben = '0;
    bus_x.re = 1'b0; bus_x.we = 1'b0; bus_x.priv = 1'b0;
    bus_x.addr = '0; bus_x.wdata = '0; bus_x.ben = '0;
    imem_ack = 1'b0; dmem_ack = 1'b0; io_ack = 1'b0; ext_ack = 1'b0;
    imem_err = 1'b0; dmem_err = 1'b0; io_err = 1'b0; ext_err = 1'b0;
    imem_rdata = 32'h1111_1111; dmem_rdata = 32'h2222_2222;
    io_rdata = 32'h3333_3333; ext_rdata = 32'h4444_4444;
  endtask

  task automatic respond(input gw_sel_t s, input logic ack, input logic err);
    case (s)
      SEL_IMEM: begin imem_ack = ack; imem_err = err; end
      SEL_DMEM: begin dmem_ack = ack; dmem_err = err; end
      SEL_IO:   begin io_ack = ack; io_err = err; end
      SEL_EXT:  begin ext_ack = ack; ext_err = err; end
      default:  ;
    endcase
  endtask

  function automatic logic [7:0] exp_strb(input gw_sel_t s, input logic re, input logic we);
    case (s)
      SEL_IMEM: return {we, re, 6'b0};
      SEL_DMEM: return {2'b0, we, re, 4'b0};
      SEL_IO:   return {4'b0, we, re, 2'b0};
      SEL_EXT:  return {6'b0, we, re};
      default:  return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] rdata_of(input gw_sel_t s);
    case (s)
      SEL_IMEM: return 32'h1111_1111;
      SEL_DMEM: return 32'h2222_2222;
      SEL_IO:   return 32'h3333_3333;
      SEL_EXT:  return 32'h4444_4444;
      default:  return 32'h0;
    endcase
  endfunction

  typedef struct {
    string       name;
    logic        re;
    logic        we;
    logic        priv;
    logic [31:0] addr;
    gw_sel_t     sel;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"rd_imem",        1'b1, 1'b0, 1'b1, 32'h0000_0100, SEL_IMEM};
    vecs[1]  = '{"wr_imem_top",    1'b0, 1'b1, 1'b0, 32'h0000_3FFC, SEL_IMEM};
    vecs[2]  = '{"rd_past_imem",   1'b1, 1'b0, 1'b1, 32'h0000_4000, SEL_NONE};
    vecs[3]  = '{"rd_dmem_user",   1'b1, 1'b0, 1'b0, 32'h8000_0000, SEL_DMEM};
    vecs[4]  = '{"wr_dmem_top",    1'b0, 1'b1, 1'b1, 32'h8000_1FFF, SEL_DMEM};
    vecs[5]  = '{"rd_past_dmem",   1'b1, 1'b0, 1'b1, 32'h8000_2000, SEL_NONE};
    vecs[6]  = '{"wr_io_user",     1'b0, 1'b1, 1'b0, 32'hFFFF_FE10, SEL_NONE};
    vecs[7]  = '{"wr_io_mach",     1'b0, 1'b1, 1'b1, 32'hFFFF_FE10, SEL_IO};
    vecs[8]  = '{"rd_io_top",      1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, SEL_IO};
    vecs[9]  = '{"rd_below_io",    1'b1, 1'b0, 1'b1, 32'hFFFF_FDFC, SEL_NONE};
    vecs[10] = '{"re_and_we",      1'b1, 1'b1, 1'b1, 32'h0000_0100, SEL_NONE};
    vecs[11] = '{"rd_unmapped",    1'b1, 1'b0, 1'b1, 32'h4000_0000, SEL_NONE};

    clear_inputs();
    rst = 1'b1;
    repeat (3) next_cycle();
    rst = 1'b0;
    sample();
    check("rst_strb", 32'(strb), 32'h0);
    check("rst_ack", 32'(bus.ack), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);

    // Table: strobe in cycle 0, response (target ack or gateway error) in cycle 1.
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      clear_inputs();
      bus.re = vecs[i].re; bus.we = vecs[i].we; bus.priv = vecs[i].priv;
      bus.addr = vecs[i].addr; bus.wdata = 32'hC0DE_0000 + 32'(i); bus.ben = 4'(i);
      sample();
      check({vecs[i].name, "_strb"}, 32'(strb), 32'(exp_strb(vecs[i].sel, vecs[i].re, vecs[i].we)));
      check({vecs[i].name, "_c0_resp"}, 32'({bus.ack, bus.err}), 32'h0);
      check({vecs[i].name, "_t_addr"}, t_addr, vecs[i].addr);
      check({vecs[i].name, "_t_wdata"}, t_wdata, 32'hC0DE_0000 + 32'(i));
      check({vecs[i].name, "_t_ben"}, 32'(t_ben), 32'(i[3:0]));
      next_cycle();
      clear_inputs();
      respond(vecs[i].sel, 1'b1, 1'b0);
      sample();
      check({vecs[i].name, "_ack"}, 32'(bus.ack), 32'(vecs[i].sel != SEL_NONE));
      check({vecs[i].name, "_err"}, 32'(bus.err), 32'(vecs[i].sel == SEL_NONE));
      check({vecs[i].name, "_rdata"}, bus.rdata, rdata_of(vecs[i].sel));
    end

    // IMEM read with a dropped DMEM strobe in cycle 1, then ack+err together in cycle 2.
    next_cycle(); clear_inputs();
    bus.re = 1'b1; bus.priv = 1'b1; bus.addr = 32'h0000_0100;
    sample();
    check("ovl_imem_re", 32'(imem_re), 32'h1);
    next_cycle(); clear_inputs();
    bus.re = 1'b1; bus.priv = 1'b1; bus.addr = 32'h8000_0000;
    sample();
    check("ovl_dmem_dropped", 32'(strb), 32'h0);
    check("ovl_wait_resp", 32'({bus.ack, bus.err}), 32'h0);
    next_cycle(); clear_inputs();
    imem_ack = 1'b1; imem_err = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    sample();
    check("ovl_err_wins_err", 32'(bus.err), 32'h1);
    check("ovl_err_wins_ack", 32'(bus.ack), 32'h0);
    next_cycle(); clear_inputs();
    sample();
    check("ovl_back_idle", 32'({bus.ack, bus.err}), 32'h0);

    // Read 0x100 with ack in cycle 2; an unselected DMEM ack in cycle 1 is ignored.
    next_cycle(); clear_inputs();
    bus.re = 1'b1; bus.priv = 1'b1; bus.addr = 32'h0000_0100;
    sample();
    check("rd2_strb", 32'(strb), 32'h40);
    next_cycle(); clear_inputs();
    dmem_ack = 1'b1;
    sample();
    check("rd2_unsel_ack", 32'(bus.ack), 32'h0);
    next_cycle(); clear_inputs();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    sample();
    check("rd2_ack", 32'(bus.ack), 32'h1);
    check("rd2_rdata", bus.rdata, 32'hDEAD_BEEF);

    // Reset during an outstanding IMEM read; a late ack must not surface.
    next_cycle(); clear_inputs();
    bus.re = 1'b1; bus.priv = 1'b1; bus.addr = 32'h0000_0200;
    sample();
    check("mrst_imem_re", 32'(imem_re), 32'h1);
    next_cycle(); clear_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    sample();
    check("mrst_outputs", 32'({strb, bus.ack, bus.err}), 32'h0);
    check("mrst_rdata", bus.rdata, 32'h0);
    next_cycle(); clear_inputs();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    sample();
    check("mrst_late_ack", 32'(bus.ack), 32'h0);
    check("mrst_late_rdata", bus.rdata, 32'h0);

    // External region on the EXT_EN=1 instance: ack in cycle 3.
    next_cycle(); clear_inputs();
    bus_x.re = 1'b1; bus_x.priv = 1'b1; bus_x.addr = 32'h4000_0000;
    sample();
    check("ext_re", 32'({x_ext_re, x_imem_re, x_dmem_re, x_io_re}), 32'h8);
    next_cycle(); clear_inputs();
    sample();
    check("ext_c1_ack", 32'(bus_x.ack), 32'h0);
    next_cycle(); clear_inputs();
    sample();
    check("ext_c2_ack", 32'(bus_x.ack), 32'h0);
    next_cycle(); clear_inputs();
    ext_ack = 1'b1; ext_rdata = 32'hABCD_0123;
    sample();
    check("ext_c3_ack", 32'(bus_x.ack), 32'h1);
    check("ext_c3_rdata", bus_x.rdata, 32'hABCD_0123);
    check("ext_dut0_ignores", 32'(bus.ack), 32'h0);

    // DMEM read with no response, then a late ack in cycle 6.
    next_cycle(); clear_inputs();
    bus.re = 1'b1; bus.priv = 1'b1; bus.addr = 32'h8000_0040;
    sample();
    check("tmo_dmem_re", 32'(dmem_re), 32'h1);
    for (int c = 1; c <= 3; c++) begin
      next_cycle(); clear_inputs();
      sample();
      check("tmo_wait_err", 32'(bus.err), 32'h0);
    end
    next_cycle(); clear_inputs();
    sample();
`ifdef CELLRV32_BUS_GATEWAY_TIMEOUT_EN
    check("tmo_c4_err", 32'(bus.err), 32'h1);
`else
    check("tmo_c4_no_err", 32'(bus.err), 32'h0);
`endif
    next_cycle(); clear_inputs();
    sample();
    check("tmo_c5_err", 32'(bus.err), 32'h0);
    next_cycle(); clear_inputs();
    dmem_ack = 1'b1;
    sample();
`ifdef CELLRV32_BUS_GATEWAY_TIMEOUT_EN
    check("tmo_late_ack", 32'(bus.ack), 32'h0);
`else
    check("notmo_ack", 32'(bus.ack), 32'h1);
`endif

    // Ack in the cycle the timeout would expire: the ack wins.
    next_cycle(); clear_inputs();
    bus.re = 1'b1; bus.priv = 1'b1; bus.addr = 32'h8000_0080;
    sample();
    for (int c = 1; c <= 3; c++) begin
      next_cycle(); clear_inputs();
    end
    next_cycle(); clear_inputs();
    dmem_ack = 1'b1;
    sample();
    check("tmo_edge_ack", 32'(bus.ack), 32'h1);
    check("tmo_edge_err", 32'(bus.err), 32'h0);

    next_cycle(); clear_inputs();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
